// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one alucode ALU between two requesters:
// one operation in flight, operands held for ALU_WAIT cycles, result returned on a response channel.
module alu_req_arbiter #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_a,
    input  logic [3:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [7:0]  rsp0_data,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [7:0]  rsp1_data,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [7:0]  alu_out,
    output logic        busy,
    output logic [15:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [3:0]  opA_q, opA_d;
    logic [3:0]  opB_q, opB_d;
    logic [1:0]  opCode_q, opCode_d;
    logic [7:0]  result_q, result_d;
    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [15:0] doneCnt_q, doneCnt_d;

    logic        grant0;
    logic        grant1;
    logic        rspReady;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            opA_q     <= 4'd0;
            opB_q     <= 4'd0;
            opCode_q  <= 2'd0;
            result_q  <= 8'd0;
            waitCnt_q <= 4'd0;
            doneCnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opCode_q  <= opCode_d;
            result_q  <= result_d;
            waitCnt_q <= waitCnt_d;
            doneCnt_q <= doneCnt_d;
        end
    end

    // Under contention the requester that was not served last wins; a lone requester always wins.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        opCode_d   = opCode_q;
        result_d   = result_q;
        waitCnt_d  = waitCnt_q;
        doneCnt_d  = doneCnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;

        grant0   = req0_valid && (!req1_valid || last_q);
        grant1   = req1_valid && (!req0_valid || !last_q);
        rspReady = owner_q ? rsp1_ready : rsp0_ready;

        case (state_q)
            IDLE: begin
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (req0_ready || req1_ready) begin
                    owner_d   = req1_ready;
                    opA_d     = req1_ready ? req1_a  : req0_a;
                    opB_d     = req1_ready ? req1_b  : req0_b;
                    opCode_d  = req1_ready ? req1_op : req0_op;
                    waitCnt_d = WAIT_LOAD;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (waitCnt_q == 4'd0) begin
                    result_d = alu_out;
                    state_d  = RESP;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                if (rspReady) begin
                    doneCnt_d = doneCnt_q + 16'd1;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign alu_a     = opA_q;
    assign alu_b     = opB_q;
    assign alu_op    = opCode_q;
    assign rsp0_data = result_q;
    assign rsp1_data = result_q;
    assign busy      = (state_q != IDLE);
    assign done_cnt  = doneCnt_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one instance with ALU_WAIT=1 and one with ALU_WAIT=3,
// sharing stimulus; a multiplier stub stands in for the ALU.
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0Valid, req1Valid;
    logic [3:0] req0A, req0B, req1A, req1B;
    logic [1:0] req0Op, req1Op;
    logic       rsp0Ready, rsp1Ready;
    logic       sel;

    logic        req0ReadyW1, req1ReadyW1, rsp0ValidW1, rsp1ValidW1, busyW1;
    logic [7:0]  rsp0DataW1, rsp1DataW1, aluOutW1;
    logic [3:0]  aluAW1, aluBW1;
    logic [1:0]  aluOpW1;
    logic [15:0] doneW1;

    logic        req0ReadyW3, req1ReadyW3, rsp0ValidW3, rsp1ValidW3, busyW3;
    logic [7:0]  rsp0DataW3, rsp1DataW3, aluOutW3;
    logic [3:0]  aluAW3, aluBW3;
    logic [1:0]  aluOpW3;
    logic [15:0] doneW3;

    logic        obsReq0Ready, obsReq1Ready, obsRsp0Valid, obsRsp1Valid, obsBusy;
    logic [7:0]  obsRsp0Data, obsRsp1Data;
    logic [3:0]  obsAluA, obsAluB;
    logic [1:0]  obsAluOp;
    logic [15:0] obsDone;

    int checks = 0;
    int errors = 0;

    assign aluOutW1 = {4'd0, aluAW1} * {4'd0, aluBW1};
    assign aluOutW3 = {4'd0, aluAW3} * {4'd0, aluBW3};

    alu_req_arbiter #(.ALU_WAIT(1)) u_dutW1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0Valid), .req0_ready(req0ReadyW1), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
        .req1_valid(req1Valid), .req1_ready(req1ReadyW1), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
        .rsp0_valid(rsp0ValidW1), .rsp0_ready(rsp0Ready), .rsp0_data(rsp0DataW1),
        .rsp1_valid(rsp1ValidW1), .rsp1_ready(rsp1Ready), .rsp1_data(rsp1DataW1),
        .alu_a(aluAW1), .alu_b(aluBW1), .alu_op(aluOpW1), .alu_out(aluOutW1),
        .busy(busyW1), .done_cnt(doneW1)
    );

    alu_req_arbiter #(.ALU_WAIT(3)) u_dutW3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0Valid), .req0_ready(req0ReadyW3), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
        .req1_valid(req1Valid), .req1_ready(req1ReadyW3), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
        .rsp0_valid(rsp0ValidW3), .rsp0_ready(rsp0Ready), .rsp0_data(rsp0DataW3),
        .rsp1_valid(rsp1ValidW3), .rsp1_ready(rsp1Ready), .rsp1_data(rsp1DataW3),
        .alu_a(aluAW3), .alu_b(aluBW3), .alu_op(aluOpW3), .alu_out(aluOutW3),
        .busy(busyW3), .done_cnt(doneW3)
    );

    // sel picks which instance the checks look at: 0 -> ALU_WAIT=1, 1 -> ALU_WAIT=3.
    always_comb begin
        if (sel) begin
            obsReq0Ready = req0ReadyW3; obsReq1Ready = req1ReadyW3;
            obsRsp0Valid = rsp0ValidW3; obsRsp1Valid = rsp1ValidW3;
            obsRsp0Data  = rsp0DataW3;  obsRsp1Data  = rsp1DataW3;
            obsAluA = aluAW3; obsAluB = aluBW3; obsAluOp = aluOpW3;
            obsBusy = busyW3; obsDone = doneW3;
        end else begin
            obsReq0Ready = req0ReadyW1; obsReq1Ready = req1ReadyW1;
            obsRsp0Valid = rsp0ValidW1; obsRsp1Valid = rsp1ValidW1;
            obsRsp0Data  = rsp0DataW1;  obsRsp1Data  = rsp1DataW1;
            obsAluA = aluAW1; obsAluB = aluBW1; obsAluOp = aluOpW1;
            obsBusy = busyW1; obsDone = doneW1;
        end
    end

    typedef struct {
        logic       reqSel;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs[6];

    task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                                 input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] op1);
        req0Valid = v0; req0A = a0; req0B = b0; req0Op = op0;
        req1Valid = v1; req1A = a1; req1B = b1; req1Op = op1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle after rst_n rises.
    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int expDone;
        int nResp;
        int overlap;
        int dualGrant;
        int sawRsp;
        logic       respOwner[2];
        logic [7:0] respData[2];
        int         respCycle[2];

        vecs[0] = '{1'b0, 4'd6,  4'd2,  2'd1, 8'h0C};
        vecs[1] = '{1'b1, 4'd7,  4'd8,  2'd2, 8'h38};
        vecs[2] = '{1'b0, 4'd0,  4'd9,  2'd3, 8'h00};
        vecs[3] = '{1'b1, 4'd15, 4'd1,  2'd0, 8'h0F};
        vecs[4] = '{1'b0, 4'd12, 4'd11, 2'd2, 8'h84};
        vecs[5] = '{1'b1, 4'd5,  4'd13, 2'd1, 8'h41};

        // Reset held two cycles with req0 already asking, then the single op on ALU_WAIT=1.
        sel = 1'b0;
        rst_n = 1'b0;
        rsp0Ready = 1'b1;
        rsp1Ready = 1'b1;
        applyStimulus(1'b1, 4'd6, 4'd2, 2'd1, 1'b0, 4'd0, 4'd0, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("reset req0_ready", obsReq0Ready, 1'b0);
        checkOutput("reset req1_ready", obsReq1Ready, 1'b0);
        checkOutput("reset rsp0_valid", obsRsp0Valid, 1'b0);
        checkOutput("reset rsp1_valid", obsRsp1Valid, 1'b0);
        checkOutput("reset busy", obsBusy, 1'b0);
        checkOutput("reset done_cnt", obsDone, 16'd0);
        checkOutput("reset busy W3", busyW3, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("single req0_ready cycle0", obsReq0Ready, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        #2;
        checkOutput("single alu_op cycle1", obsAluOp, 2'd1);
        checkOutput("single alu_a cycle1", obsAluA, 4'd6);
        checkOutput("single busy cycle1", obsBusy, 1'b1);
        checkOutput("single rsp0_valid cycle1", obsRsp0Valid, 1'b0);
        nextCycle();
        #2;
        checkOutput("single rsp0_valid cycle2", obsRsp0Valid, 1'b1);
        checkOutput("single rsp0_data cycle2", obsRsp0Data, 8'h0C);
        checkOutput("single rsp1_valid cycle2", obsRsp1Valid, 1'b0);
        nextCycle();
        #2;
        checkOutput("single done_cnt", obsDone, 16'd1);
        checkOutput("single busy after", obsBusy, 1'b0);

        // Table of isolated operations, alternating requesters, ALU_WAIT=1.
        expDone = 1;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            if (vecs[i].reqSel)
                applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            else
                applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 4'd0, 4'd0, 2'd0);
            #2;
            checkOutput($sformatf("vec%0d done_cnt", i), obsDone, expDone);
            checkOutput($sformatf("vec%0d ready", i), vecs[i].reqSel ? obsReq1Ready : obsReq0Ready, 1'b1);
            nextCycle();
            applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
            #2;
            checkOutput($sformatf("vec%0d alu_op", i), obsAluOp, vecs[i].op);
            checkOutput($sformatf("vec%0d alu_b", i), obsAluB, vecs[i].b);
            lat = 1;
            while (!(vecs[i].reqSel ? obsRsp1Valid : obsRsp0Valid) && lat < 20) begin
                nextCycle();
                #2;
                lat++;
            end
            checkOutput($sformatf("vec%0d latency", i), lat, 2);
            checkOutput($sformatf("vec%0d data", i), vecs[i].reqSel ? obsRsp1Data : obsRsp0Data, vecs[i].expData);
            checkOutput($sformatf("vec%0d other valid", i), vecs[i].reqSel ? obsRsp0Valid : obsRsp1Valid, 1'b0);
            expDone++;
        end
        nextCycle();
        #2;
        checkOutput("table final done_cnt", obsDone, expDone);

        // Contention: both held valid from reset, req0 must go first, then req1.
        doReset();
        applyStimulus(1'b1, 4'd3, 4'd5, 2'd0, 1'b1, 4'd15, 4'd15, 2'd0);
        #2;
        nResp = 0;
        overlap = 0;
        dualGrant = 0;
        for (int c = 0; c < 30; c++) begin
            if (nResp < 2) begin
                if (obsRsp0Valid && obsRsp1Valid) overlap++;
                if (obsReq0Ready && obsReq1Ready) dualGrant++;
                if (obsRsp0Valid || obsRsp1Valid) begin
                    respOwner[nResp] = obsRsp1Valid;
                    respData[nResp]  = obsRsp1Valid ? obsRsp1Data : obsRsp0Data;
                    respCycle[nResp] = c;
                    nResp++;
                end
                nextCycle();
                #2;
            end
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        checkOutput("contention response count", nResp, 2);
        if (nResp == 2) begin
            checkOutput("contention first owner", respOwner[0], 1'b0);
            checkOutput("contention first data", respData[0], 8'h0F);
            checkOutput("contention first cycle", respCycle[0], 2);
            checkOutput("contention second owner", respOwner[1], 1'b1);
            checkOutput("contention second data", respData[1], 8'hE1);
            checkOutput("contention second cycle", respCycle[1], 5);
        end
        checkOutput("contention overlapping valids", overlap, 0);
        checkOutput("contention dual grants", dualGrant, 0);

        // Backpressure on ALU_WAIT=3: req1 result held while req0 waits.
        sel = 1'b1;
        rsp1Ready = 1'b0;
        doReset();
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 4'd9, 4'd7, 2'd2);
        #2;
        checkOutput("bp req1_ready cycle0", obsReq1Ready, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 4'd2, 4'd3, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        #2;
        checkOutput("bp req0_ready in EXEC", obsReq0Ready, 1'b0);
        lat = 1;
        while (!obsRsp1Valid && lat < 20) begin
            nextCycle();
            #2;
            lat++;
        end
        checkOutput("bp latency", lat, 4);
        checkOutput("bp rsp1_data", obsRsp1Data, 8'h3F);
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            #2;
            checkOutput($sformatf("bp hold%0d rsp1_valid", k), obsRsp1Valid, 1'b1);
            checkOutput($sformatf("bp hold%0d rsp1_data", k), obsRsp1Data, 8'h3F);
            checkOutput($sformatf("bp hold%0d req0_ready", k), obsReq0Ready, 1'b0);
            checkOutput($sformatf("bp hold%0d busy", k), obsBusy, 1'b1);
        end
        nextCycle();
        rsp1Ready = 1'b1;
        #2;
        checkOutput("bp req0_ready at release", obsReq0Ready, 1'b0);
        nextCycle();
        #2;
        checkOutput("bp req0_ready after release", obsReq0Ready, 1'b1);
        checkOutput("bp rsp1_valid after release", obsRsp1Valid, 1'b0);
        checkOutput("bp done_cnt", obsDone, 16'd1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);

        // Reset during EXEC on ALU_WAIT=3 discards the operation.
        doReset();
        applyStimulus(1'b1, 4'd4, 4'd4, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0);
        #2;
        checkOutput("midrst req0_ready", obsReq0Ready, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        #2;
        checkOutput("midrst busy in EXEC", obsBusy, 1'b1);
        nextCycle();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        sawRsp = 0;
        for (int k = 0; k < 12; k++) begin
            #2;
            if (obsRsp0Valid || obsRsp1Valid) sawRsp++;
            nextCycle();
        end
        checkOutput("midrst no response", sawRsp, 0);
        checkOutput("midrst done_cnt", obsDone, 16'd0);
        checkOutput("midrst busy", obsBusy, 1'b0);

        // done_cnt wrap on ALU_WAIT=1 with the counter preset to all ones.
        sel = 1'b0;
        doReset();
        force u_dutW1.doneCnt_q = 16'hFFFF;
        #1;
        release u_dutW1.doneCnt_q;
        #1;
        checkOutput("wrap preset", obsDone, 16'hFFFF);
        nextCycle();
        applyStimulus(1'b1, 4'd1, 4'd1, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        #2;
        checkOutput("wrap req0_ready", obsReq0Ready, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
        nextCycle();
        #2;
        checkOutput("wrap rsp0_valid", obsRsp0Valid, 1'b1);
        checkOutput("wrap done before handshake", obsDone, 16'hFFFF);
        nextCycle();
        #2;
        checkOutput("wrap done_cnt", obsDone, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
